// File: rtl/bookkeeping_directory_requester_pkg.sv
// Shared widths, enums and packed layouts for the bookkeeping-directory put/get protocol.
// Field order of put_request_t and entry_t matches the directory side bit for bit.
package bookkeeping_dir_pkg;
  localparam int unsigned INDEX_WIDTH    = 12;
  localparam int unsigned TAG_WIDTH      = 18;
  localparam int unsigned MSI_STATE_SIZE = 2;
  localparam int unsigned ROW_WIDTH      = TAG_WIDTH + MSI_STATE_SIZE;
  localparam int unsigned REQ_WIDTH      = INDEX_WIDTH + 1 + ROW_WIDTH + 2;
  localparam int unsigned ENTRY_WIDTH    = 4 * ROW_WIDTH;

  typedef enum logic {
    OP_LOOKUP = 1'b0,
    OP_UPDATE = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

  typedef struct packed {
    logic [MSI_STATE_SIZE-1:0] msi_state;
    logic [TAG_WIDTH-1:0]      tag;
  } row_t;

  typedef struct packed {
    logic [INDEX_WIDTH-1:0] idx;
    logic                   write_valid;
    row_t                   row;
    logic                   core_id;
    logic                   cache_type;
  } put_request_t;

  typedef struct packed {
    row_t imem0;
    row_t dmem0;
    row_t imem1;
    row_t dmem1;
  } entry_t;
endpackage

// File: rtl/bookkeeping_directory_requester_if.sv
// Handshake bundles: controller <-> requester (ctrl) and requester <-> directory (dir).
interface bookkeeping_ctrl_if;
  import bookkeeping_dir_pkg::*;
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_is_update;
  logic [INDEX_WIDTH-1:0] req_idx;
  logic [ROW_WIDTH-1:0]   req_row;
  logic                   req_core_id;
  logic                   req_cache_type;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [ENTRY_WIDTH-1:0] resp_entry;
  logic [ROW_WIDTH-1:0]   resp_row;

  modport master (
    output req_valid, req_is_update, req_idx, req_row, req_core_id, req_cache_type, resp_ready,
    input  req_ready, resp_valid, resp_entry, resp_row
  );
  modport slave (
    input  req_valid, req_is_update, req_idx, req_row, req_core_id, req_cache_type, resp_ready,
    output req_ready, resp_valid, resp_entry, resp_row
  );
endinterface

interface bookkeeping_dir_if;
  import bookkeeping_dir_pkg::*;
  logic                   dir_put_valid;
  logic                   dir_put_ready;
  logic [REQ_WIDTH-1:0]   dir_put_request;
  logic                   dir_get_valid;
  logic                   dir_get_ready;
  logic [ENTRY_WIDTH-1:0] dir_get_response;

  modport master (
    output dir_put_valid, dir_put_request, dir_get_valid,
    input  dir_put_ready, dir_get_ready, dir_get_response
  );
  modport slave (
    input  dir_put_valid, dir_put_request, dir_get_valid,
    output dir_put_ready, dir_get_ready, dir_get_response
  );
endinterface

// File: rtl/bookkeeping_directory_requester_row_select.sv
// Picks one row of a directory entry by {core_id, cache_type}: 00=imem0 .. 11=dmem1.
module bookkeeping_row_select
  import bookkeeping_dir_pkg::*;
(
  input  entry_t entry,
  input  logic   core_id,
  input  logic   cache_type,
  output row_t   row
);
  always_comb begin
    row = '0;
    unique case ({core_id, cache_type})
      2'b00:   row = entry.imem0;
      2'b01:   row = entry.dmem0;
      2'b10:   row = entry.imem1;
      default: row = entry.dmem1;
    endcase
  end
endmodule

// File: rtl/bookkeeping_directory_requester.sv
// Initiator for directory LOOKUP/UPDATE ops, one op in flight, all outputs registered or state-decoded.
// Optional DIR_REQ_STATS_EN adds saturating lookup_count/update_count outputs.
module bookkeeping_directory_requester
  import bookkeeping_dir_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  bookkeeping_ctrl_if.slave  ctrl,
  bookkeeping_dir_if.master  dir
`ifdef DIR_REQ_STATS_EN
  ,
  output logic [15:0]        lookup_count,
  output logic [15:0]        update_count
`endif
);
  state_e                 state_q;
  logic                   req_ready_q;
  logic                   put_valid_q;
  logic                   get_valid_q;
  logic                   resp_valid_q;
  entry_t                 resp_entry_q;
  op_e                    op_q;
  logic [INDEX_WIDTH-1:0] idx_q;
  row_t                   row_q;
  logic                   core_q;
  logic                   cache_q;
  put_request_t           put_req;
  row_t                   sel_row;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      req_ready_q  <= 1'b1;
      put_valid_q  <= 1'b0;
      get_valid_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_entry_q <= '0;
      op_q         <= OP_LOOKUP;
      idx_q        <= '0;
      row_q        <= '0;
      core_q       <= 1'b0;
      cache_q      <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (ctrl.req_valid && req_ready_q) begin
            op_q        <= ctrl.req_is_update ? OP_UPDATE : OP_LOOKUP;
            idx_q       <= ctrl.req_idx;
            // LOOKUP carries a zero row so the put request needs no masking later
            row_q       <= ctrl.req_is_update ? row_t'(ctrl.req_row) : row_t'('0);
            core_q      <= ctrl.req_core_id;
            cache_q     <= ctrl.req_cache_type;
            req_ready_q <= 1'b0;
            put_valid_q <= 1'b1;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (dir.dir_put_ready) begin
            put_valid_q <= 1'b0;
            if (op_q == OP_UPDATE) begin
              req_ready_q <= 1'b1;
              state_q     <= ST_IDLE;
            end else begin
              get_valid_q <= 1'b1;
              state_q     <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (dir.dir_get_ready) begin
            get_valid_q  <= 1'b0;
            resp_entry_q <= entry_t'(dir.dir_get_response);
            resp_valid_q <= 1'b1;
            state_q      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (ctrl.resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    put_req             = '0;
    put_req.idx         = idx_q;
    put_req.write_valid = (op_q == OP_UPDATE);
    put_req.row         = row_q;
    put_req.core_id     = core_q;
    put_req.cache_type  = cache_q;
  end

  bookkeeping_row_select u_row_select (
    .entry      (resp_entry_q),
    .core_id    (core_q),
    .cache_type (cache_q),
    .row        (sel_row)
  );

  assign ctrl.req_ready     = req_ready_q;
  assign ctrl.resp_valid    = resp_valid_q;
  assign ctrl.resp_entry    = resp_entry_q;
  assign ctrl.resp_row      = sel_row;
  assign dir.dir_put_valid   = put_valid_q;
  assign dir.dir_put_request = put_req;
  assign dir.dir_get_valid   = get_valid_q;

`ifdef DIR_REQ_STATS_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      lookup_count <= '0;
      update_count <= '0;
    end else if (state_q == ST_ISSUE && dir.dir_put_ready) begin
      if (op_q == OP_UPDATE) begin
        if (update_count != 16'hFFFF) update_count <= update_count + 16'd1;
      end else begin
        if (lookup_count != 16'hFFFF) lookup_count <= lookup_count + 16'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_bookkeeping_directory_requester.sv
// Directed bench for bookkeeping_directory_requester with a behavioural directory and a result scoreboard.
// Define DIR_REQ_STATS_EN to also exercise the op counters.
module tb_bookkeeping_directory_requester;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checks = 0;
  int   failures = 0;

  logic [79:0] exp_mem [logic [11:0]];
  logic [79:0] dir_mem [logic [11:0]];
  logic [79:0] sb_entry [$];
  logic [19:0] sb_row [$];

  bookkeeping_ctrl_if ctrl_if ();
  bookkeeping_dir_if  dir_if ();

`ifdef DIR_REQ_STATS_EN
  logic [15:0] lookup_count;
  logic [15:0] update_count;
`endif

  bookkeeping_directory_requester dut (
    .CLK  (CLK),
    .RST  (RST),
    .ctrl (ctrl_if),
    .dir  (dir_if)
`ifdef DIR_REQ_STATS_EN
    ,
    .lookup_count (lookup_count),
    .update_count (update_count)
`endif
  );

  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Row slot of {core,cache} inside an 80-bit entry: 00 sits in the top 20 bits.
  function automatic int slot_lsb(input logic [1:0] s);
    return (3 - int'(s)) * 20;
  endfunction

  task automatic do_op(input logic upd, input logic [11:0] idx, input logic [19:0] row,
                       input logic core, input logic ct, input int unsigned stall, input int unsigned hold);
    logic [34:0] exp_req;
    logic [34:0] got_req;
    logic [79:0] cur;
    logic [79:0] e;
    logic [19:0] r;
    exp_req = {idx, upd, (upd ? row : 20'h0), core, ct};
    cur = exp_mem.exists(idx) ? exp_mem[idx] : 80'h0;
    if (upd) begin
      cur[slot_lsb({core, ct}) +: 20] = row;
      exp_mem[idx] = cur;
    end else begin
      sb_entry.push_back(cur);
      sb_row.push_back(cur[slot_lsb({core, ct}) +: 20]);
    end
    chk("idle_req_ready", 128'(ctrl_if.req_ready), 128'(1));
    ctrl_if.req_valid      = 1'b1;
    ctrl_if.req_is_update  = upd;
    ctrl_if.req_idx        = idx;
    ctrl_if.req_row        = row;
    ctrl_if.req_core_id    = core;
    ctrl_if.req_cache_type = ct;
    @(negedge CLK);
    ctrl_if.req_valid = 1'b0;
    ctrl_if.req_row   = 20'h0;
    for (int unsigned i = 0; i < stall; i++) begin
      chk("stall_put_valid", 128'(dir_if.dir_put_valid), 128'(1));
      chk("stall_put_req", 128'(dir_if.dir_put_request), 128'(exp_req));
      chk("stall_req_ready", 128'(ctrl_if.req_ready), 128'(0));
      @(negedge CLK);
    end
    chk("put_valid", 128'(dir_if.dir_put_valid), 128'(1));
    chk("put_req", 128'(dir_if.dir_put_request), 128'(exp_req));
    chk("issue_get_valid", 128'(dir_if.dir_get_valid), 128'(0));
    got_req = dir_if.dir_put_request;
    dir_if.dir_put_ready = 1'b1;
    @(negedge CLK);
    dir_if.dir_put_ready = 1'b0;
    if (got_req[22]) begin
      cur = dir_mem.exists(got_req[34:23]) ? dir_mem[got_req[34:23]] : 80'h0;
      cur[slot_lsb(got_req[1:0]) +: 20] = got_req[21:2];
      dir_mem[got_req[34:23]] = cur;
    end
    if (upd) begin
      chk("upd_req_ready", 128'(ctrl_if.req_ready), 128'(1));
      chk("upd_put_valid", 128'(dir_if.dir_put_valid), 128'(0));
    end else begin
      chk("wait_get_valid", 128'(dir_if.dir_get_valid), 128'(1));
      chk("wait_put_valid", 128'(dir_if.dir_put_valid), 128'(0));
      chk("wait_req_ready", 128'(ctrl_if.req_ready), 128'(0));
      dir_if.dir_get_response = dir_mem.exists(got_req[34:23]) ? dir_mem[got_req[34:23]] : 80'h0;
      dir_if.dir_get_ready = 1'b1;
      @(negedge CLK);
      dir_if.dir_get_ready = 1'b0;
      dir_if.dir_get_response = 80'h0;
      e = sb_entry.pop_front();
      r = sb_row.pop_front();
      chk("resp_valid", 128'(ctrl_if.resp_valid), 128'(1));
      chk("resp_get_valid", 128'(dir_if.dir_get_valid), 128'(0));
      for (int unsigned i = 0; i < hold; i++) begin
        @(negedge CLK);
        chk("hold_resp_valid", 128'(ctrl_if.resp_valid), 128'(1));
        chk("hold_resp_entry", 128'(ctrl_if.resp_entry), 128'(e));
        chk("hold_req_ready", 128'(ctrl_if.req_ready), 128'(0));
        chk("hold_put_valid", 128'(dir_if.dir_put_valid), 128'(0));
      end
      chk("resp_entry", 128'(ctrl_if.resp_entry), 128'(e));
      chk("resp_row", 128'(ctrl_if.resp_row), 128'(r));
      ctrl_if.resp_ready = 1'b1;
      @(negedge CLK);
      ctrl_if.resp_ready = 1'b0;
      chk("done_resp_valid", 128'(ctrl_if.resp_valid), 128'(0));
      chk("done_req_ready", 128'(ctrl_if.req_ready), 128'(1));
    end
  endtask

  initial begin
    ctrl_if.req_valid = 1'b0;
    ctrl_if.req_is_update = 1'b0;
    ctrl_if.req_idx = 12'h0;
    ctrl_if.req_row = 20'h0;
    ctrl_if.req_core_id = 1'b0;
    ctrl_if.req_cache_type = 1'b0;
    ctrl_if.resp_ready = 1'b0;
    dir_if.dir_put_ready = 1'b0;
    dir_if.dir_get_ready = 1'b0;
    dir_if.dir_get_response = 80'h0;
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    chk("rst_req_ready", 128'(ctrl_if.req_ready), 128'(1));
    chk("rst_resp_valid", 128'(ctrl_if.resp_valid), 128'(0));
    chk("rst_put_valid", 128'(dir_if.dir_put_valid), 128'(0));
    chk("rst_get_valid", 128'(dir_if.dir_get_valid), 128'(0));
    chk("rst_resp_entry", 128'(ctrl_if.resp_entry), 128'(0));

    // Stray get_ready / resp_ready while idle must do nothing.
    dir_if.dir_get_ready = 1'b1;
    ctrl_if.resp_ready = 1'b1;
    dir_if.dir_get_response = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
    @(negedge CLK);
    dir_if.dir_get_ready = 1'b0;
    ctrl_if.resp_ready = 1'b0;
    dir_if.dir_get_response = 80'h0;
    chk("ign_req_ready", 128'(ctrl_if.req_ready), 128'(1));
    chk("ign_resp_valid", 128'(ctrl_if.resp_valid), 128'(0));
    chk("ign_resp_entry", 128'(ctrl_if.resp_entry), 128'(0));

    do_op(1'b1, 12'h123, 20'h80ABC, 1'b1, 1'b1, 0, 0);
    do_op(1'b0, 12'h123, 20'h0, 1'b0, 1'b0, 0, 0);
    do_op(1'b1, 12'h200, 20'h3FFFF, 1'b0, 1'b1, 5, 0);
    do_op(1'b0, 12'h123, 20'hFFFFF, 1'b1, 1'b1, 0, 10);
    for (int i = 0; i < 4; i++) begin
      logic [1:0] s;
      s = 2'(i);
      do_op(1'b1, 12'h055, 20'(i + 1), s[1], s[0], 0, 0);
    end
    for (int i = 0; i < 4; i++) begin
      logic [1:0] s;
      s = 2'(i);
      do_op(1'b0, 12'h055, 20'h0, s[1], s[0], 0, 0);
    end
    do_op(1'b0, 12'h200, 20'h0, 1'b0, 1'b1, 2, 1);

    // Reset while the DUT waits on the directory response.
    ctrl_if.req_valid = 1'b1;
    ctrl_if.req_is_update = 1'b0;
    ctrl_if.req_idx = 12'h055;
    ctrl_if.req_core_id = 1'b0;
    ctrl_if.req_cache_type = 1'b0;
    @(negedge CLK);
    ctrl_if.req_valid = 1'b0;
    dir_if.dir_put_ready = 1'b1;
    @(negedge CLK);
    dir_if.dir_put_ready = 1'b0;
    chk("midwait_get_valid", 128'(dir_if.dir_get_valid), 128'(1));
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    exp_mem.delete();
    dir_mem.delete();
    chk("midrst_req_ready", 128'(ctrl_if.req_ready), 128'(1));
    chk("midrst_get_valid", 128'(dir_if.dir_get_valid), 128'(0));
    chk("midrst_resp_valid", 128'(ctrl_if.resp_valid), 128'(0));
    chk("midrst_put_valid", 128'(dir_if.dir_put_valid), 128'(0));
    chk("midrst_resp_entry", 128'(ctrl_if.resp_entry), 128'(0));
    do_op(1'b0, 12'h055, 20'h0, 1'b1, 1'b0, 0, 0);

`ifdef DIR_REQ_STATS_EN
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    exp_mem.delete();
    dir_mem.delete();
    chk("stat_rst_lookup", 128'(lookup_count), 128'(0));
    do_op(1'b0, 12'h001, 20'h0, 1'b0, 1'b0, 0, 0);
    do_op(1'b1, 12'h001, 20'h00007, 1'b0, 1'b0, 0, 0);
    do_op(1'b0, 12'h001, 20'h0, 1'b0, 1'b0, 0, 0);
    do_op(1'b1, 12'h002, 20'h00009, 1'b1, 1'b0, 1, 0);
    do_op(1'b0, 12'h002, 20'h0, 1'b1, 1'b0, 0, 0);
    chk("stat_lookup", 128'(lookup_count), 128'(3));
    chk("stat_update", 128'(update_count), 128'(2));
    force dut.lookup_count = 16'hFFFF;
    force dut.update_count = 16'hFFFF;
    @(negedge CLK);
    release dut.lookup_count;
    release dut.update_count;
    do_op(1'b0, 12'h002, 20'h0, 1'b0, 1'b0, 0, 0);
    do_op(1'b1, 12'h002, 20'h00001, 1'b0, 1'b0, 0, 0);
    chk("stat_lookup_sat", 128'(lookup_count), 128'(16'hFFFF));
    chk("stat_update_sat", 128'(update_count), 128'(16'hFFFF));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
